// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snake_pkg
//  Purpose  : Shared constants for the snake game score display path:
//             active-low seven-segment patterns (gfedcba), display FSM
//             state encoding and BCD digit width.
//  Revision : 1.0  initial release
// ============================================================================
package snake_pkg;

    localparam int BCD_BIT = 4;

    // Active-low segment patterns, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/score_display_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : score_display_driver_if
//  Purpose  : Bundle between the game core / board pins and the score
//             display driver. The master side supplies score and control
//             levels; the slave side (the driver) returns segment drives
//             and status.
//  Revision : 1.0  initial release
// ============================================================================
interface score_display_driver_if #(
    parameter int SCORE_BIT = 7
);
    logic [SCORE_BIT-1:0] score;
    logic                 game_over;
    logic                 show_high;
    logic [6:0]           hex0;
    logic [6:0]           hex1;
    logic [6:0]           hex2;
    logic                 busy;
    logic                 update;
    logic [SCORE_BIT-1:0] high_score;
    logic                 new_record;

    modport master (
        output score, game_over, show_high,
        input  hex0, hex1, hex2, busy, update, high_score, new_record
    );

    modport slave (
        input  score, game_over, show_high,
        output hex0, hex1, hex2, busy, update, high_score, new_record
    );
endinterface
`default_nettype wire

// File: rtl/score_display_driver_bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_seg7
//  Purpose  : Combinational BCD digit to active-low seven-segment decoder
//             with a blanking input. Non-decimal codes also blank.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_to_seg7
    import snake_pkg::*;
(
    input  wire logic [BCD_BIT-1:0] i_bcd,
    input  wire logic               i_blank,
    output logic      [6:0]         o_seg
);

    // Pattern lookup; blank overrides the digit value
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/score_display_driver.sv
`default_nettype none
// ============================================================================
//  Module   : score_display_driver
//  Purpose  : Converts the game score to three active-low seven-segment
//             digits using a sequential shift-add-3 (double dabble) FSM,
//             with leading-zero blanking. Optional high-score tracking is
//             compiled in when HIGH_SCORE_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module score_display_driver
    import snake_pkg::*;
#(
    parameter int SCORE_BIT  = 7,
    parameter int NUM_DIGITS = 3
)(
    input  wire logic              clock_25,
    input  wire logic              reset,
    score_display_driver_if.slave  bus
);

    localparam int BCD_W   = BCD_BIT * NUM_DIGITS;
    localparam int SHIFT_W = BCD_W + SCORE_BIT;
    localparam int CNT_W   = $clog2(SCORE_BIT + 1);

    state_t                 state_q, state_d;
    logic [SCORE_BIT-1:0]   shown_value_q, shown_value_d;
    logic [SHIFT_W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [6:0]             hex_q [NUM_DIGITS];
    logic [6:0]             hex_d [NUM_DIGITS];
    logic                   update_q, update_d;

    logic [SCORE_BIT-1:0]   w_source;
    logic [SHIFT_W-1:0]     w_adj;
    logic [BCD_BIT-1:0]     w_digit [NUM_DIGITS];
    logic                   w_blank [NUM_DIGITS];
    logic [6:0]             w_seg   [NUM_DIGITS];
    logic                   w_leading;

    // ------------------------------------------------------------------
    // High-score tracking (optional)
    // ------------------------------------------------------------------
`ifdef HIGH_SCORE_EN
    logic                 game_over_q, game_over_d;
    logic [SCORE_BIT-1:0] high_score_q, high_score_d;
    logic                 new_record_q, new_record_d;

    // Latch a strictly better score on the rising edge of game_over
    always_comb begin
        game_over_d  = bus.game_over;
        high_score_d = high_score_q;
        new_record_d = 1'b0;
        if (bus.game_over && !game_over_q && (bus.score > high_score_q)) begin
            high_score_d = bus.score;
            new_record_d = 1'b1;
        end
    end

    // High-score registers; cleared only by reset
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            game_over_q  <= 1'b0;
            high_score_q <= '0;
            new_record_q <= 1'b0;
        end else begin
            game_over_q  <= game_over_d;
            high_score_q <= high_score_d;
            new_record_q <= new_record_d;
        end
    end

    assign w_source       = bus.show_high ? high_score_q : bus.score;
    assign bus.high_score = high_score_q;
    assign bus.new_record = new_record_q;
`else
    logic unused_feature_w;

    assign unused_feature_w = ^{bus.game_over, bus.show_high};
    assign w_source         = bus.score;
    assign bus.high_score   = '0;
    assign bus.new_record   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Digit extraction, blanking and decoders
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign w_digit[g] = shift_q[SCORE_BIT + g*BCD_BIT +: BCD_BIT];

        bcd_to_seg7 u_dec (
            .i_bcd   (w_digit[g]),
            .i_blank (w_blank[g]),
            .o_seg   (w_seg[g])
        );
    end

    // A digit blanks while it and every digit above it are zero; units never blank
    always_comb begin
        w_leading = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_leading  = w_leading & (w_digit[i] == '0);
            w_blank[i] = w_leading & (i != 0);
        end
    end

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    // Next-state and datapath: add-3 correction then shift each SHIFT cycle
    always_comb begin
        state_d       = state_q;
        shown_value_d = shown_value_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        hex_d         = hex_q;
        update_d      = 1'b0;

        w_adj = shift_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_adj[SCORE_BIT + i*BCD_BIT +: BCD_BIT] >= 4'd5) begin
                w_adj[SCORE_BIT + i*BCD_BIT +: BCD_BIT] =
                    w_adj[SCORE_BIT + i*BCD_BIT +: BCD_BIT] + 4'd3;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (w_source != shown_value_q) begin
                    shown_value_d = w_source;
                    shift_d       = {{BCD_W{1'b0}}, w_source};
                    cnt_d         = '0;
                    state_d       = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d = {w_adj[SHIFT_W-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SCORE_BIT - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    hex_d[i] = w_seg[i];
                end
                update_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and display registers; reset aborts any conversion in flight
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shown_value_q <= '0;
            shift_q       <= '0;
            cnt_q         <= '0;
            update_q      <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_q[i] <= (i == 0) ? SEG_0 : SEG_BLANK;
            end
        end else begin
            state_q       <= state_d;
            shown_value_q <= shown_value_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            update_q      <= update_d;
            hex_q         <= hex_d;
        end
    end

    assign bus.hex0   = hex_q[0];
    assign bus.hex1   = hex_q[1];
    assign bus.hex2   = hex_q[2];
    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.update = update_q;

endmodule
`default_nettype wire

// File: tb/tb_score_display_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_display_driver
//  Purpose  : Directed self-checking bench for score_display_driver.
//  Revision : 1.0  initial release
// ============================================================================
module tb_score_display_driver;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   pulses;

    score_display_driver_if #(.SCORE_BIT(7)) bus ();

    score_display_driver #(
        .SCORE_BIT  (7),
        .NUM_DIGITS (3)
    ) dut (
        .clock_25 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Busy for 8 sampled cycles, then the new digits with a single update pulse
    task automatic wait_conv(input string tag, input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
            check({tag, " no early update"}, {31'd0, bus.update}, 32'd0);
        end
        @(negedge clk);
        check({tag, " busy done"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " update"}, {31'd0, bus.update}, 32'd1);
        check({tag, " hex2"}, {25'd0, bus.hex2}, {25'd0, e2});
        check({tag, " hex1"}, {25'd0, bus.hex1}, {25'd0, e1});
        check({tag, " hex0"}, {25'd0, bus.hex0}, {25'd0, e0});
        @(negedge clk);
        check({tag, " update single"}, {31'd0, bus.update}, 32'd0);
    endtask

    task automatic convert(input string tag, input logic [6:0] val, input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
        bus.score = val;
        wait_conv(tag, e2, e1, e0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        pulses = 0;
        rst = 1'b1;
        bus.score = 7'd0;
        bus.game_over = 1'b0;
        bus.show_high = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset hex0", {25'd0, bus.hex0}, {25'd0, S0});
        check("reset hex1", {25'd0, bus.hex1}, {25'd0, SB});
        check("reset hex2", {25'd0, bus.hex2}, {25'd0, SB});
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset update", {31'd0, bus.update}, 32'd0);
        check("reset high_score", {25'd0, bus.high_score}, 32'd0);
        check("reset new_record", {31'd0, bus.new_record}, 32'd0);

        // Idle with unchanged score: no conversion, no pulse
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.update || bus.busy) pulses++;
        end
        check("idle quiet", pulses, 32'd0);
        check("idle hex0", {25'd0, bus.hex0}, {25'd0, S0});

        // Main conversions including blanking boundaries
        convert("42", 7'd42, SB, S4, S2);
        convert("127", 7'd127, S1, S2, S7);
        convert("100", 7'd100, S1, S0, S0);
        convert("9", 7'd9, SB, SB, S9);

        // Change during SHIFT: 5 shown first, 6 follows 9 cycles later
        bus.score = 7'd5;
        @(negedge clk);
        @(negedge clk);
        bus.score = 7'd6;
        repeat (6) @(negedge clk);
        check("5 busy before update", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        check("5 update", {31'd0, bus.update}, 32'd1);
        check("5 hex0", {25'd0, bus.hex0}, {25'd0, S5});
        check("5 hex1", {25'd0, bus.hex1}, {25'd0, SB});
        @(negedge clk);
        check("6 restarts busy", {31'd0, bus.busy}, 32'd1);
        check("6 update cleared", {31'd0, bus.update}, 32'd0);
        repeat (7) @(negedge clk);
        check("6 no early update", {31'd0, bus.update}, 32'd0);
        @(negedge clk);
        check("6 update", {31'd0, bus.update}, 32'd1);
        check("6 hex0", {25'd0, bus.hex0}, {25'd0, S6});

        // Reset mid-conversion aborts; afterwards the current score converts
        @(negedge clk);
        bus.score = 7'd99;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort hex0", {25'd0, bus.hex0}, {25'd0, S0});
        check("abort hex1", {25'd0, bus.hex1}, {25'd0, SB});
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort update", {31'd0, bus.update}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("abort hold update", {31'd0, bus.update}, 32'd0);
        rst = 1'b0;
        wait_conv("99 after reset", SB, S9, S9);

        // Unchanged score does not reconvert
        repeat (4) @(negedge clk);
        check("steady busy", {31'd0, bus.busy}, 32'd0);

        // High-score tracking
        convert("30", 7'd30, SB, S3, S0);
        bus.game_over = 1'b1;
        @(negedge clk);
`ifdef HIGH_SCORE_EN
        check("record 30 value", {25'd0, bus.high_score}, 32'd30);
        check("record 30 pulse", {31'd0, bus.new_record}, 32'd1);
        @(negedge clk);
        check("record pulse single", {31'd0, bus.new_record}, 32'd0);
`else
        check("disabled high_score", {25'd0, bus.high_score}, 32'd0);
        check("disabled new_record", {31'd0, bus.new_record}, 32'd0);
        @(negedge clk);
`endif
        bus.game_over = 1'b0;
        @(negedge clk);
        convert("20", 7'd20, SB, S2, S0);
        bus.game_over = 1'b1;
        @(negedge clk);
`ifdef HIGH_SCORE_EN
        check("lower score keeps", {25'd0, bus.high_score}, 32'd30);
`else
        check("disabled high_score 2", {25'd0, bus.high_score}, 32'd0);
`endif
        check("lower score no pulse", {31'd0, bus.new_record}, 32'd0);
        bus.game_over = 1'b0;
        @(negedge clk);
        bus.show_high = 1'b1;
`ifdef HIGH_SCORE_EN
        wait_conv("show_high 30", SB, S3, S0);
`else
        repeat (10) @(negedge clk);
        check("show_high ignored busy", {31'd0, bus.busy}, 32'd0);
        check("show_high ignored hex1", {25'd0, bus.hex1}, {25'd0, S2});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_display_driver.md
Name: score_display_driver

Overview:
- Consumes the 7-bit `score` produced by the snake game core and drives three active-low seven-segment digits on the board.
- Conversion uses a multi-cycle shift-add-3 (double-dabble) FSM; leading zeros are blanked.
- Sits directly downstream of the game core, in parallel with the VGA graphic path.
- Optional high-score tracking latches the best score at game over.

Parameters:
- SCORE_BIT, 7, width of `score` input; also the number of shift iterations.
- NUM_DIGITS, 3, BCD digits produced (enough for the maximum value 127).

Ports:
- clock_25  in  1  25 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- score  in  SCORE_BIT  current score from the game core.
- game_over  in  1  level from the game core, high while in game-over state.
- show_high  in  1  when high, display the high score instead of score (feature only).
- hex0  out  7  units digit, segments gfedcba, active-low.
- hex1  out  7  tens digit, active-low.
- hex2  out  7  hundreds digit, active-low.
- busy  out  1  high while a conversion is in progress.
- update  out  1  one-cycle pulse when hex0..hex2 are rewritten.
- high_score  out  SCORE_BIT  best score so far (feature only).
- new_record  out  1  one-cycle pulse when high_score is replaced (feature only).

Behaviour:
- Reset values:
  - hex0=7'b1000000 ("0"); hex1=hex2=7'b1111111 (blank).
  - busy=0, update=0, high_score=0, new_record=0.
  - Internal shown_value=0; FSM in IDLE.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: the source is high_score if (feature enabled and show_high=1), otherwise score.
  - If source != shown_value: latch source into shown_value, load the shift register with {12'b0, source}, clear the iteration counter, go to SHIFT, busy=1.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per cycle:
  - Each BCD nibble >= 5 gets +3.
  - Then the whole register shifts left by 1 and the counter increments.
  - After SCORE_BIT iterations go to DONE.
- DONE: write hex0..hex2 from the BCD nibbles, pulse update=1, busy=0, return to IDLE.
- Latency:
  - Source sampled at IDLE edge k; iterations at edges k+1..k+7; registers written at edge k+8.
  - Outputs show the new value after exactly 8 cycles.
  - Minimum spacing between updates is 9 cycles.
- Source changes during SHIFT/DONE are ignored. IDLE re-compares afterwards, so the final value is always displayed and intermediate values may be skipped.
- Blanking:
  - hex2 is blank when hundreds=0.
  - hex1 is blank when hundreds=0 and tens=0.
  - hex0 is never blank.
- Segment codes (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Reset asserted mid-conversion aborts immediately to the reset values above; there is no partial display update.
- Inputs are synchronous to clock_25; no internal synchronizers.

Optional Feature:
- Macro: HIGH_SCORE_EN.
- Enabled:
  - Detect the rising edge of game_over (registered delay).
  - On that edge, if score > high_score: high_score<=score and new_record pulses for 1 cycle.
  - Equal scores do not update.
  - show_high selects high_score as the display source; toggling it triggers reconversion through the normal IDLE compare.
  - high_score survives game restarts; it is cleared only by reset.
- Disabled:
  - high_score tied to 0, new_record tied to 0, show_high ignored.
  - No edge-detect registers are inferred.

Decomposition:
- Shared package snake_pkg holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK;
  - the FSM state encoding (2-bit IDLE/SHIFT/DONE);
  - BCD_BIT=4.
- One natural sub-module: bcd_to_seg7, a combinational 4-bit-to-7-segment decoder with a blank input, instantiated NUM_DIGITS times.

Test Plan:
- Reset then idle 20 cycles -> hex0=1000000, hex1=hex2=1111111, busy=0, update never pulses.
- score 0->42 at edge k -> busy high k..k+7; at k+8 hex2=1111111, hex1=0011001, hex0=0100100, update=1 for one cycle.
- score=127 -> hex2=1111001, hex1=0100100, hex0=1111000; then score=100 -> hex2=1111001, hex1=1000000 (not blanked), hex0=1000000.
- score 5 then 6 two cycles later (mid-SHIFT) -> first update shows "5"; a second conversion follows and shows "6" 9 cycles after the first update.
- Assert reset at iteration 4 of a conversion to 99 -> outputs return to reset values at once, no update pulse; after release the display converts the current score.
- HIGH_SCORE_EN: score=30, game_over rises -> high_score=30, new_record one pulse. Next game score=20, game_over rises -> no change. show_high=1 -> display "30" after 8 cycles.
